// File: rtl/mips_pkg.sv
// Shared types for the MIPS load/store unit: access sizes and LSU FSM states.
package mips_pkg;

   typedef enum logic [1:0] {
      BYTE  = 2'd0,
      HALF  = 2'd1,
      WORD  = 2'd2,
      DWORD = 2'd3
   } mem_size_t;

   typedef enum logic [1:0] {
      IDLE,
      READ_WAIT,
      WRITE,
      RESP
   } lsu_state_t;

endpackage

// File: rtl/mem_lane_align.sv
// Byte-lane shifter: EXTRACT=0 places right-justified store data onto lanes,
// EXTRACT=1 pulls the selected lanes down and zero/sign-extends them.
module mem_lane_align
   import mips_pkg::*;
#(
   parameter int unsigned XLEN    = 32,
   parameter bit          EXTRACT = 1'b0
) (
   input  logic [XLEN-1:0]           data_in,
   input  mem_size_t                 size,
   input  logic [$clog2(XLEN/8)-1:0] offset,
   input  logic                      sign_ext,
   output logic [XLEN-1:0]           data_out,
   output logic [XLEN/8-1:0]         byte_en
);

   localparam int unsigned LANES = XLEN / 8;

   int unsigned nbytes;
   int unsigned off;
   logic        fill;

   always_comb begin
      data_out = '0;
      byte_en  = '0;
      fill     = 1'b0;
      nbytes   = 32'd1 << size;
      if (nbytes > LANES) nbytes = LANES;
      off = 32'(offset);

      if (EXTRACT) begin
         for (int unsigned k = 0; k < LANES; k++)
            if (k + 1 == off + nbytes) fill = sign_ext & data_in[8*k+7];
         for (int unsigned i = 0; i < LANES; i++) begin
            if (i < nbytes) begin
               for (int unsigned k = 0; k < LANES; k++)
                  if (k == i + off) data_out[8*i +: 8] = data_in[8*k +: 8];
            end else begin
               data_out[8*i +: 8] = {8{fill}};
            end
         end
      end else begin
         for (int unsigned i = 0; i < LANES; i++) begin
            if (i >= off && i < off + nbytes) begin
               byte_en[i] = 1'b1;
               for (int unsigned k = 0; k < LANES; k++)
                  if (k + off == i) data_out[8*i +: 8] = data_in[8*k +: 8];
            end
         end
      end
   end

endmodule

// File: rtl/mips_lsu.sv
// Load/store unit between a MIPS core and a fixed-latency byte-lane memory.
// Optional macro MIPS_LSU_MISALIGN_EXC_EN: misaligned accesses fault instead of being aligned down.
module mips_lsu
   import mips_pkg::*;
#(
   parameter int unsigned XLEN        = 32,
   parameter int unsigned MEM_LATENCY = 2
) (
   input  logic                    clk,
   input  logic                    rst_b,
   input  logic                    req_valid,
   output logic                    req_ready,
   input  logic                    req_write,
   input  logic [1:0]              req_size,
   input  logic                    req_signed,
   input  logic [XLEN-1:0]         req_addr,
   input  logic [XLEN-1:0]         req_wdata,
   output logic                    resp_valid,
   output logic [XLEN-1:0]         resp_rdata,
   output logic                    resp_err,
   output logic                    stall,
   output logic [XLEN-1:0]         mem_addr,
   output logic [XLEN/8-1:0][7:0]  mem_data_out,
   input  logic [XLEN/8-1:0][7:0]  mem_data_in,
   output logic                    mem_write_en,
   output logic [XLEN/8-1:0]       mem_byte_en
);

   localparam int unsigned LANES = XLEN / 8;
   localparam int unsigned OFF_W = $clog2(LANES);

   lsu_state_t       state, state_next;
   mem_size_t        size_eff, op_size;
   logic             op_signed;
   logic [XLEN-1:0]  op_addr, op_wdata, load_result, store_data, load_data;
   logic [LANES-1:0] store_be, unused_load_be;
   logic [OFF_W-1:0] off_mask, req_off;
   logic [3:0]       wait_cnt;
   logic             accept, read_done, misalign_exc;

   assign accept    = req_valid && (state == IDLE);
   assign read_done = (state == READ_WAIT) && (wait_cnt == 4'(MEM_LATENCY));

   // Sizes wider than the bus collapse to full width; off_mask covers the bits natural alignment clears.
   always_comb begin
      size_eff = mem_size_t'(req_size);
      if (32'(req_size) > OFF_W) size_eff = mem_size_t'(2'(OFF_W));
      off_mask = '0;
      for (int unsigned i = 0; i < OFF_W; i++) off_mask[i] = (i < 32'(size_eff));
      req_off = req_addr[OFF_W-1:0] & ~off_mask;
   end

`ifdef MIPS_LSU_MISALIGN_EXC_EN
   logic op_err;

   assign misalign_exc = |(req_addr[OFF_W-1:0] & off_mask);

   always_ff @(posedge clk or posedge rst_b) begin
      if (rst_b)       op_err <= 1'b0;
      else if (accept) op_err <= misalign_exc;
   end

   assign resp_err = (state == RESP) && op_err;
`else
   assign misalign_exc = 1'b0;
   assign resp_err     = 1'b0;
`endif

   always_ff @(posedge clk or posedge rst_b) begin
      if (rst_b) state <= IDLE;
      else       state <= state_next;
   end

   always_comb begin
      state_next = state;
      case (state)
         IDLE: begin
            if (accept) begin
               if (misalign_exc)   state_next = RESP;
               else if (req_write) state_next = WRITE;
               else                state_next = READ_WAIT;
            end
         end
         READ_WAIT: if (read_done) state_next = RESP;
         WRITE:     state_next = RESP;
         RESP:      state_next = IDLE;
         default:   state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst_b) begin
      if (rst_b) begin
         op_size     <= BYTE;
         op_signed   <= 1'b0;
         op_addr     <= '0;
         op_wdata    <= '0;
         wait_cnt    <= '0;
         load_result <= '0;
      end else begin
         if (accept) begin
            op_size     <= size_eff;
            op_signed   <= req_signed;
            op_addr     <= {req_addr[XLEN-1:OFF_W], req_off};
            op_wdata    <= req_wdata;
            wait_cnt    <= 4'd1;
            load_result <= '0;
         end else if (state == READ_WAIT) begin
            wait_cnt <= wait_cnt + 4'd1;
         end
         if (read_done) load_result <= load_data;
      end
   end

   mem_lane_align #(.XLEN(XLEN), .EXTRACT(1'b0)) u_store_align (
      .data_in  (op_wdata),
      .size     (op_size),
      .offset   (op_addr[OFF_W-1:0]),
      .sign_ext (1'b0),
      .data_out (store_data),
      .byte_en  (store_be)
   );

   mem_lane_align #(.XLEN(XLEN), .EXTRACT(1'b1)) u_load_align (
      .data_in  (mem_data_in),
      .size     (op_size),
      .offset   (op_addr[OFF_W-1:0]),
      .sign_ext (op_signed),
      .data_out (load_data),
      .byte_en  (unused_load_be)
   );

   assign req_ready    = (state == IDLE);
   assign stall        = (state != IDLE);
   assign resp_valid   = (state == RESP);
   assign resp_rdata   = resp_valid ? load_result : '0;
   assign mem_addr     = {op_addr[XLEN-1:OFF_W], {OFF_W{1'b0}}};
   assign mem_data_out = store_data;
   assign mem_write_en = (state == WRITE);
   assign mem_byte_en  = mem_write_en ? store_be : '0;

endmodule

// File: tb/tb_mips_lsu.sv
// Directed bench for mips_lsu (XLEN=32, MEM_LATENCY=2) with a byte-array memory behind it.
module tb_mips_lsu;
   import mips_pkg::*;

   localparam int unsigned XLEN = 32;
   localparam int          LAT  = 2;

   logic             clk, rst_b;
   logic             req_valid, req_ready, req_write, req_signed;
   logic [1:0]       req_size;
   logic [31:0]      req_addr, req_wdata, resp_rdata, mem_addr;
   logic             resp_valid, resp_err, stall, mem_write_en;
   logic [3:0][7:0]  mem_data_out, mem_data_in;
   logic [3:0]       mem_byte_en;
   logic [7:0]       mem [0:16383];
   int               checks   = 0;
   int               failures = 0;

   mips_lsu #(.XLEN(XLEN), .MEM_LATENCY(LAT)) dut (
      .clk          (clk),
      .rst_b        (rst_b),
      .req_valid    (req_valid),
      .req_ready    (req_ready),
      .req_write    (req_write),
      .req_size     (req_size),
      .req_signed   (req_signed),
      .req_addr     (req_addr),
      .req_wdata    (req_wdata),
      .resp_valid   (resp_valid),
      .resp_rdata   (resp_rdata),
      .resp_err     (resp_err),
      .stall        (stall),
      .mem_addr     (mem_addr),
      .mem_data_out (mem_data_out),
      .mem_data_in  (mem_data_in),
      .mem_write_en (mem_write_en),
      .mem_byte_en  (mem_byte_en)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk)
      if (mem_write_en)
         for (int i = 0; i < 4; i++)
            if (mem_byte_en[i]) mem[mem_addr[13:0] + 14'(i)] <= mem_data_out[i];

   always_comb
      for (int j = 0; j < 4; j++) mem_data_in[j] = mem[mem_addr[13:0] + 14'(j)];

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   // Presents a request at cycle T and returns at the negedge of T+1 with inputs scrambled.
   task automatic issue(input logic wr, input logic [1:0] size, input logic sgn,
                        input logic [31:0] addr, input logic [31:0] data);
      @(negedge clk);
      req_valid  = 1'b1;
      req_write  = wr;
      req_size   = size;
      req_signed = sgn;
      req_addr   = addr;
      req_wdata  = data;
      check("idle_ready", req_ready, 1);
      check("idle_noresp", resp_valid, 0);
      @(negedge clk);
      req_valid  = 1'b0;
      req_write  = ~wr;
      req_size   = ~size;
      req_signed = ~sgn;
      req_addr   = ~addr;
      req_wdata  = ~data;
   endtask

   task automatic wait_resp(input string tag, input int start, input int exp_lat);
      int n;
      n = start;
      while (resp_valid !== 1'b1 && n < 20) begin
         @(negedge clk);
         n++;
      end
      check({tag, "_lat"}, n, exp_lat);
   endtask

   task automatic store_op(input string tag, input logic [31:0] addr, input logic [1:0] size,
                           input logic [31:0] data, input logic [3:0] exp_be,
                           input logic [31:0] exp_lanes);
      logic [31:0] mask;
      for (int i = 0; i < 4; i++) mask[8*i +: 8] = {8{exp_be[i]}};
      issue(1'b1, size, 1'b0, addr, data);
      check({tag, "_we"}, mem_write_en, 1);
      check({tag, "_be"}, mem_byte_en, exp_be);
      check({tag, "_lanes"}, mem_data_out & mask, exp_lanes);
      check({tag, "_maddr"}, mem_addr, {addr[31:2], 2'b00});
      @(negedge clk);
      check({tag, "_we_drop"}, mem_write_en, 0);
      wait_resp(tag, 2, 2);
      check({tag, "_rdata"}, resp_rdata, 0);
      check({tag, "_err"}, resp_err, 0);
   endtask

   task automatic load_op(input string tag, input logic [31:0] addr, input logic [1:0] size,
                          input logic sgn, input logic [31:0] exp_data, input logic [31:0] exp_maddr);
      issue(1'b0, size, sgn, addr, 32'hA5A5_5A5A);
      check({tag, "_maddr"}, mem_addr, exp_maddr);
      check({tag, "_we"}, mem_write_en, 0);
      check({tag, "_stall"}, stall, 1);
      wait_resp(tag, 1, LAT + 1);
      check({tag, "_rdata"}, resp_rdata, exp_data);
      check({tag, "_err"}, resp_err, 0);
   endtask

   initial begin
      rst_b      = 1'b0;
      req_valid  = 1'b0;
      req_write  = 1'b0;
      req_size   = 2'd0;
      req_signed = 1'b0;
      req_addr   = '0;
      req_wdata  = '0;
      #2 rst_b = 1'b1;
      #1;
      check("rst_ready", req_ready, 1);
      check("rst_stall", stall, 0);
      check("rst_resp", resp_valid, 0);
      check("rst_err", resp_err, 0);
      check("rst_rdata", resp_rdata, 0);
      check("rst_we", mem_write_en, 0);
      check("rst_be", mem_byte_en, 0);
      check("rst_maddr", mem_addr, 0);
      @(negedge clk);
      @(negedge clk);
      rst_b = 1'b0;

      store_op("st_zero", 32'h1000, WORD, 32'h0000_0000, 4'b1111, 32'h0000_0000);
      store_op("st_byte", 32'h1003, BYTE, 32'h0000_00AB, 4'b1000, 32'hAB00_0000);
      load_op("ld_ab", 32'h1000, WORD, 1'b0, 32'hAB00_0000, 32'h1000);
      store_op("st_half", 32'h1002, HALF, 32'hDEAD_BEEF, 4'b1100, 32'hBEEF_0000);

`ifdef MIPS_LSU_MISALIGN_EXC_EN
      issue(1'b1, HALF, 1'b0, 32'h1001, 32'h0000_1234);
      check("st_mis_resp", resp_valid, 1);
      check("st_mis_err", resp_err, 1);
      check("st_mis_we", mem_write_en, 0);
      check("st_mis_rdata", resp_rdata, 0);
      load_op("ld_mis_chk", 32'h1000, WORD, 1'b0, 32'hBEEF_0000, 32'h1000);
`else
      store_op("st_mis", 32'h1001, HALF, 32'h0000_1234, 4'b0011, 32'h0000_1234);
      load_op("ld_mis_chk", 32'h1000, WORD, 1'b0, 32'hBEEF_1234, 32'h1000);
`endif

      store_op("st_2000", 32'h2000, WORD, 32'hFF80_2211, 4'b1111, 32'hFF80_2211);
      load_op("ld_sh", 32'h2002, HALF, 1'b1, 32'hFFFF_FF80, 32'h2000);
      load_op("ld_uh", 32'h2002, HALF, 1'b0, 32'h0000_FF80, 32'h2000);
      load_op("ld_sb", 32'h2002, BYTE, 1'b1, 32'hFFFF_FF80, 32'h2000);
      load_op("ld_sb_pos", 32'h2000, BYTE, 1'b1, 32'h0000_0011, 32'h2000);
      load_op("ld_ub", 32'h2001, BYTE, 1'b0, 32'h0000_0022, 32'h2000);
      load_op("ld_w", 32'h2000, WORD, 1'b0, 32'hFF80_2211, 32'h2000);
      load_op("ld_dw", 32'h2000, DWORD, 1'b1, 32'hFF80_2211, 32'h2000);

      store_op("st_3000", 32'h3000, WORD, 32'h0403_0201, 4'b1111, 32'h0403_0201);
`ifdef MIPS_LSU_MISALIGN_EXC_EN
      issue(1'b0, WORD, 1'b0, 32'h3001, 32'h0);
      check("ld_mis_resp", resp_valid, 1);
      check("ld_mis_err", resp_err, 1);
      check("ld_mis_rdata", resp_rdata, 0);
      check("ld_mis_we", mem_write_en, 0);
`else
      load_op("ld_mis", 32'h3001, WORD, 1'b0, 32'h0403_0201, 32'h3000);
`endif

      // Reset in the middle of a load: no response, ready at once.
      issue(1'b0, WORD, 1'b0, 32'h2000, 32'h0);
      rst_b = 1'b1;
      #1;
      check("rrd_ready", req_ready, 1);
      check("rrd_stall", stall, 0);
      check("rrd_maddr", mem_addr, 0);
      @(negedge clk);
      rst_b = 1'b0;
      for (int c = 0; c < LAT + 2; c++) begin
         @(negedge clk);
         check("rrd_noresp", resp_valid, 0);
      end
      load_op("rrd_next", 32'h2000, WORD, 1'b0, 32'hFF80_2211, 32'h2000);

      // Reset during a store drops the strobe without a clock edge.
      issue(1'b1, WORD, 1'b0, 32'h3000, 32'hCAFE_F00D);
      check("rwr_we_pre", mem_write_en, 1);
      rst_b = 1'b1;
      #1;
      check("rwr_we", mem_write_en, 0);
      check("rwr_be", mem_byte_en, 0);
      @(negedge clk);
      rst_b = 1'b0;
      @(negedge clk);
      check("rwr_noresp", resp_valid, 0);
      load_op("rwr_mem", 32'h3000, WORD, 1'b0, 32'h0403_0201, 32'h3000);

      // Back-to-back: req_valid held high across the whole first operation.
      @(negedge clk);
      req_valid  = 1'b1;
      req_write  = 1'b0;
      req_size   = WORD;
      req_signed = 1'b0;
      req_addr   = 32'h2000;
      check("b2b_ready0", req_ready, 1);
      for (int c = 1; c <= LAT + 1; c++) begin
         @(negedge clk);
         check("b2b_stall", stall, 1);
         check("b2b_busy", req_ready, 0);
      end
      check("b2b_resp1", resp_valid, 1);
      check("b2b_rdata1", resp_rdata, 32'hFF80_2211);
      @(negedge clk);
      check("b2b_idle_ready", req_ready, 1);
      check("b2b_idle_stall", stall, 0);
      check("b2b_idle_resp", resp_valid, 0);
      req_size = HALF;
      @(negedge clk);
      req_valid = 1'b0;
      check("b2b_accept2", stall, 1);
      wait_resp("b2b2", 1, LAT + 1);
      check("b2b_rdata2", resp_rdata, 32'h0000_2211);

      @(negedge clk);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1, "watchdog expired");
   end

endmodule

// File: doc/mips_lsu.md
MIPS_LSU -- requirements
Module: mips_lsu

Interface
REQ-001 Parameters SHALL be XLEN (default 32; 32 or 64; data and address width) and MEM_LATENCY (default 2; 1..15; cycles from address to valid read data).
REQ-002 Derived constant LANES = XLEN/8 SHALL set the number of byte lanes.
REQ-003 Ports SHALL be:
  clk  in  1  sole clock, rising edge
  rst_b  in  1  asynchronous, active-high reset
  req_valid  in  1  core presents a load/store
  req_ready  out  1  unit accepts request this cycle
  req_write  in  1  1 = store, 0 = load
  req_size  in  2  0 byte, 1 half, 2 word, 3 dword
  req_signed  in  1  sign-extend load result
  req_addr  in  XLEN  byte address
  req_wdata  in  XLEN  store data, right-justified
  resp_valid  out  1  one-cycle completion pulse
  resp_rdata  out  XLEN  load result, extended
  resp_err  out  1  misaligned access flag, valid with resp_valid
  stall  out  1  unit busy; core must hold its pipeline
  mem_addr  out  XLEN  word-aligned memory address
  mem_data_out  out  8 x LANES  store byte lanes, index 0..LANES-1
  mem_data_in  in  8 x LANES  read byte lanes
  mem_write_en  out  1  memory write strobe
  mem_byte_en  out  LANES  per-lane write enable

Function
REQ-004 Handshake: request accepted in cycle T when req_valid and req_ready are both 1; req_ready SHALL be 1 only in IDLE.
REQ-005 FSM states SHALL be IDLE, READ_WAIT, WRITE and RESP; IDLE->READ_WAIT on accepted load, IDLE->WRITE on accepted store, READ_WAIT->RESP when the wait counter reaches MEM_LATENCY, WRITE->RESP after one cycle, RESP->IDLE unconditionally.
REQ-006 Request fields SHALL be registered at acceptance; later input changes SHALL NOT affect the operation in flight.
REQ-007 Load: mem_addr held stable for cycles T+1..T+MEM_LATENCY; mem_data_in sampled at the end of T+MEM_LATENCY; resp_valid high in T+MEM_LATENCY+1 only.
REQ-008 Store: mem_write_en and mem_byte_en asserted in T+1 only; resp_valid high in T+2 only; resp_rdata = 0.
REQ-009 Lane mapping SHALL be little-endian: lane i holds byte at offset i of the aligned word; byte offset = req_addr[log2(LANES)-1:0].
REQ-010 Store data SHALL be placed at lanes offset..offset+2^size-1 and mem_byte_en SHALL set exactly those bits.
REQ-011 Load result SHALL be the selected 2^size bytes, zero-extended, or sign-extended from the top selected bit when req_signed = 1.
REQ-012 req_size above log2(LANES) SHALL be treated as full width (size 3 on XLEN=32 behaves as word).
REQ-013 stall SHALL be 1 in every state except IDLE.
REQ-014 resp_valid SHALL be a single-cycle pulse with no backpressure.

Reset
REQ-015 rst_b high SHALL immediately force IDLE with req_ready=1, stall=0, resp_valid=0, resp_err=0, resp_rdata=0, mem_write_en=0, mem_byte_en=0 and mem_addr=0.
REQ-016 Reset during READ_WAIT or WRITE SHALL discard the operation with no response; write strobe drops without waiting for a clock edge.

Configuration
REQ-017 With MIPS_LSU_MISALIGN_EXC_EN defined, a misaligned half, word or dword access SHALL make no memory access, go IDLE->RESP, and pulse resp_valid in T+1 with resp_err=1 and resp_rdata=0.
REQ-018 Without MIPS_LSU_MISALIGN_EXC_EN, the low address bits SHALL be cleared to natural alignment before access, and resp_err SHALL be tied 0.

Structure
REQ-019 Package mips_pkg SHALL hold the mem_size_t enum (BYTE/HALF/WORD/DWORD) and the lsu_state_t enum; mips_lsu SHALL import it.
REQ-020 Lane shifting and extension SHALL live in the combinational sub-module mem_lane_align, which is instantiated once for store placement and once for load extraction.

Verification
REQ-021 Store byte 0xAB to 0x1003 (XLEN=32) -> in T+1 mem_write_en=1, mem_byte_en=4'b1000, lane3=0xAB; resp_valid in T+2.
REQ-022 Signed half load at 0x2002 with lanes {0x11,0x22,0x80,0xFF} (index 0..3), MEM_LATENCY=2 -> resp_valid in T+3, resp_rdata=0xFFFF_FF80; unsigned gives 0x0000_FF80.
REQ-023 Word load at 0x3001 -> with macro: resp_valid in T+1, resp_err=1, no mem access; without macro: address 0x3000 used, resp_err=0.
REQ-024 Assert rst_b in T+1 of a load with MEM_LATENCY=4 -> no resp_valid; req_ready=1 immediately; next load completes normally.
REQ-025 Hold req_valid through busy cycles -> stall=1 and req_ready=0 until RESP; second request accepted in the first IDLE cycle after RESP.
